// File: rtl/score_counter.sv
// Game score counter: packed-BCD score advanced by frame ticks while running,
// with a session high score and a pulse on every 100-point milestone.
module score_counter #(
    parameter int unsigned TICKS_PER_POINT = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_frame_tick,
    input  logic        i_start,
    input  logic        i_collide,
    output logic [15:0] o_score,
    output logic [15:0] o_hi_score,
    output logic        o_running,
    output logic        o_game_over,
    output logic        o_milestone
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVER = 2'd2
    } state_e;

    localparam logic [5:0] DIV_LAST = 6'(TICKS_PER_POINT - 1);

    state_e      state_q, state_d;
    logic [5:0]  div_q, div_d;
    logic [15:0] score_q, score_d, score_inc;
    logic [15:0] hi_q, hi_d;
    logic        ms_q, ms_d;
    logic        running_q, running_d;
    logic        over_q, over_d;
    logic        carry;
    logic        saturated;

    assign saturated = (score_q == 16'h9999);

    // Ripple a +1 through the four BCD digits in a single cycle.
    always_comb begin
        score_inc = score_q;
        carry     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= '0;
            score_q   <= '0;
            hi_q      <= '0;
            ms_q      <= 1'b0;
            running_q <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            state_q   <= state_d;
            div_q     <= div_d;
            score_q   <= score_d;
            hi_q      <= hi_d;
            ms_q      <= ms_d;
            running_q <= running_d;
            over_q    <= over_d;
        end
    end

    // Next-state and datapath logic. Collide takes priority over a point.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d = state_q;
        div_d   = div_q;
        score_d = score_q;
        hi_d    = hi_q;
        ms_d    = 1'b0;
        unique case (state_q)
            IDLE, OVER: begin
                if (i_start) begin
                    state_d = RUN;
                    div_d   = '0;
                    score_d = '0;
                end
            end
            RUN: begin
                if (i_collide) begin
                    state_d = OVER;
                    if (score_q > hi_q) hi_d = score_q;
                end else if (i_frame_tick) begin
                    if (div_q == DIV_LAST) begin
                        div_d = '0;
                        if (!saturated) begin
                            score_d = score_inc;
                            ms_d    = (score_inc[7:0] == 8'h00);
                        end
                    end else begin
                        div_d = div_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode of the next state, registered alongside it.
    always_comb begin
        running_d = (state_d == RUN);
        over_d    = (state_d == OVER);
    end

    assign o_score     = score_q;
    assign o_hi_score  = hi_q;
    assign o_running   = running_q;
    assign o_game_over = over_q;
    assign o_milestone = ms_q;

endmodule

// File: tb/tb_score_counter.sv
// Bench for score_counter: two instances (6 and 1 ticks per point) checked
// every cycle against an integer-arithmetic reference model.
module tb_score_counter;

    typedef struct {
        int st;     // 0 idle, 1 run, 2 over
        int div;
        int score;
        int hi;
        bit ms;
    } model_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic a_tick = 1'b0, a_start = 1'b0, a_collide = 1'b0;
    logic b_tick = 1'b0, b_start = 1'b0, b_collide = 1'b0;
    logic [15:0] a_score, a_hi, b_score, b_hi;
    logic a_run, a_over, a_ms, b_run, b_over, b_ms;

    int checks = 0;
    int failures = 0;
    model_t ma, mb;
    bit b_ms_seen = 1'b0;

    always #5 clk = ~clk;

    score_counter #(.TICKS_PER_POINT(6)) dut_a (
        .clk(clk), .rst(rst), .i_frame_tick(a_tick), .i_start(a_start),
        .i_collide(a_collide), .o_score(a_score), .o_hi_score(a_hi),
        .o_running(a_run), .o_game_over(a_over), .o_milestone(a_ms)
    );

    score_counter #(.TICKS_PER_POINT(1)) dut_b (
        .clk(clk), .rst(rst), .i_frame_tick(b_tick), .i_start(b_start),
        .i_collide(b_collide), .o_score(b_score), .o_hi_score(b_hi),
        .o_running(b_run), .o_game_over(b_over), .o_milestone(b_ms)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic model_t model_reset();
        model_t m;
        m.st = 0; m.div = 0; m.score = 0; m.hi = 0; m.ms = 1'b0;
        return m;
    endfunction

    // Game rules in plain arithmetic: score is an ordinary integer 0..9999.
    function automatic model_t model_step(input model_t m, input bit r, input bit s,
                                          input bit c, input bit t, input int tpp);
        model_t n = m;
        if (r) return model_reset();
        n.ms = 1'b0;
        if (m.st == 1) begin
            if (c) begin
                n.st = 2;
                if (m.score > m.hi) n.hi = m.score;
            end else if (t) begin
                if (m.div == tpp - 1) begin
                    n.div = 0;
                    if (m.score < 9999) begin
                        n.score = m.score + 1;
                        n.ms    = (n.score % 100 == 0);
                    end
                end else begin
                    n.div = m.div + 1;
                end
            end
        end else if (s) begin
            n.st = 1; n.div = 0; n.score = 0;
        end
        return n;
    endfunction

    task automatic compare_all();
        check("a_score", a_score, to_bcd(ma.score));
        check("a_hi", a_hi, to_bcd(ma.hi));
        check("a_flags", {13'd0, a_run, a_over, a_ms},
              {13'd0, ma.st == 1, ma.st == 2, ma.ms});
        check("b_score", b_score, to_bcd(mb.score));
        check("b_hi", b_hi, to_bcd(mb.hi));
        check("b_flags", {13'd0, b_run, b_over, b_ms},
              {13'd0, mb.st == 1, mb.st == 2, mb.ms});
        if (b_ms) b_ms_seen = 1'b1;
    endtask

    task automatic cycle(input bit r, input bit as, input bit ac, input bit at,
                         input bit bs = 0, input bit bc = 0, input bit bt = 0);
        @(negedge clk);
        rst = r; a_start = as; a_collide = ac; a_tick = at;
        b_start = bs; b_collide = bc; b_tick = bt;
        @(posedge clk);
        ma = model_step(ma, r, as, ac, at, 6);
        mb = model_step(mb, r, bs, bc, bt, 1);
        #1;
        compare_all();
    endtask

    // n qualifying ticks on A, each preceded by a random idle gap.
    task automatic a_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) cycle(0, 0, 0, 0);
            cycle(0, 0, 0, 1);
        end
    endtask

    task automatic a_run_to(input int target);
        int budget = 2000;
        while (ma.score != target && budget > 0) begin
            a_ticks(1);
            budget--;
        end
        check("a_run_to_reached", a_score, to_bcd(target));
    endtask

    initial begin
        ma = model_reset();
        mb = model_reset();

        // Reset state.
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        check("reset_score", a_score, 16'h0000);
        check("reset_flags", {13'd0, a_run, a_over, a_ms}, 16'h0000);

        // Basic counting: 12 ticks give two points.
        cycle(0, 1, 0, 0);
        check("start_running", {15'd0, a_run}, 16'h0001);
        a_ticks(6);
        check("six_ticks", a_score, 16'h0001);
        a_ticks(6);
        check("twelve_ticks", a_score, 16'h0002);

        // Milestone at 100, none at 101.
        a_run_to(99);
        a_ticks(6);
        check("ms_score", a_score, 16'h0100);
        check("ms_pulse", {15'd0, a_ms}, 16'h0001);
        cycle(0, 0, 0, 0);
        check("ms_one_cycle", {15'd0, a_ms}, 16'h0000);
        a_ticks(6);
        check("after_ms", a_score, 16'h0101);
        check("no_ms_101", {15'd0, a_ms}, 16'h0000);

        // High score across a restart.
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        a_run_to(42);
        cycle(0, 0, 1, 0);
        check("over_flag", {15'd0, a_over}, 16'h0001);
        check("hi_42", a_hi, 16'h0042);
        a_ticks(12);
        cycle(0, 0, 1, 0);
        check("frozen", a_score, 16'h0042);
        cycle(0, 1, 0, 0);
        check("restart_score", a_score, 16'h0000);
        check("restart_hi", a_hi, 16'h0042);
        a_run_to(17);
        cycle(0, 0, 1, 0);
        check("hi_kept", a_hi, 16'h0042);

        // Collide coincident with the qualifying tick.
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        a_run_to(5);
        a_ticks(5);
        cycle(0, 0, 1, 1);
        check("collide_wins", a_score, 16'h0005);
        check("collide_hi", a_hi, 16'h0005);

        // Reset mid-run clears everything including the high score.
        cycle(1, 0, 0, 0);
        cycle(0, 1, 0, 0);
        a_run_to(42);
        cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        a_run_to(30);
        cycle(1, 0, 0, 0);
        check("rst_mid_score", a_score, 16'h0000);
        check("rst_mid_hi", a_hi, 16'h0000);
        a_ticks(12);
        cycle(0, 0, 1, 0);
        check("idle_ignores", {a_score[13:0], a_run, a_over}, 16'h0000);

        // Randomized traffic on A.
        for (int i = 0; i < 3000; i++)
            cycle(($urandom % 700) == 0, ($urandom % 40) == 0,
                  ($urandom % 80) == 0, ($urandom % 2) == 0);

        // Saturation on B (one tick per point).
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 9998; i++) cycle(0, 0, 0, 0, 0, 0, 1);
        check("b_9998", b_score, 16'h9998);
        b_ms_seen = 1'b0;
        for (int i = 0; i < 19; i++) cycle(0, 0, 0, 0, 0, 0, 1);
        check("b_sat", b_score, 16'h9999);
        check("b_sat_no_ms", {15'd0, b_ms_seen}, 16'h0000);
        cycle(0, 0, 0, 0, 0, 1, 1);
        check("b_hi_9999", b_hi, 16'h9999);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
